// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity checker: FSM state
// encoding, parity-sense constants and the parity fold helper.
package parity_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DATA    = 2'd1;
  localparam logic [1:0] ST_PAR     = 2'd2;
  localparam logic [1:0] ST_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    DATA = ST_DATA,
    PAR  = ST_PAR
  } parity_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Accumulate one serial bit into a running parity.
  function automatic logic par_fold(input logic acc, input logic bit_in);
    return acc ^ bit_in;
  endfunction

endpackage

// File: rtl/parity_err_counter.sv
// Saturating up-counter of failed frames. Only built when PARITY_ERR_CNT_EN
// is defined; otherwise the checker ties its error count to zero.
`ifdef PARITY_ERR_CNT_EN
module parity_err_counter #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [ERR_CNT_W-1:0] count
);

  // Count up on each failure, holding at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= {ERR_CNT_W{1'b0}};
    end else if (inc && (count != {ERR_CNT_W{1'b1}})) begin
      count <= count + ERR_CNT_W'(1);
    end else begin
      count <= count;
    end
  end

endmodule
`endif

// File: rtl/serial_parity_checker.sv
// Serial frame parity checker: start bit, DATA_W data bits LSB first, parity bit.
// Optional error counter is built only when PARITY_ERR_CNT_EN is defined.
module serial_parity_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ODD       = 0,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 x_valid,
  input  logic                 x,
  output logic                 parity,
  output logic [1:0]           st,
  output logic [DATA_W-1:0]    data_out,
  output logic                 frame_done,
  output logic                 frame_ok,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic             PAR_INIT = (ODD != 0) ? PAR_ODD : PAR_EVEN;

  parity_state_t     state_r;
  parity_state_t     state_nxt_s;
  logic              start_s;
  logic              shift_s;
  logic              fire_s;
  logic              par_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shreg_r;
  logic [DATA_W-1:0] data_out_r;
  logic              frame_done_r;
  logic              frame_ok_r;

  // Next-state decode and per-beat control strobes.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    shift_s     = 1'b0;
    fire_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (x_valid && !x) begin
          start_s     = 1'b1;
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        if (x_valid) begin
          shift_s = 1'b1;
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt_s = PAR;
          end else begin
            state_nxt_s = DATA;
          end
        end else begin
          state_nxt_s = DATA;
        end
      end
      PAR: begin
        if (x_valid) begin
          fire_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PAR;
        end
      end
      // Encoding 3 recovers to IDLE regardless of x_valid.
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Mealy parity: only data beats fold the live bit in.
  always_comb begin
    parity = par_r;
    if (state_r == DATA) begin
      parity = par_fold(par_r, x & x_valid);
    end else begin
      parity = par_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Deserialiser, running parity and frame result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par_r        <= PAR_INIT;
      bit_cnt_r    <= {CNT_W{1'b0}};
      shreg_r      <= {DATA_W{1'b0}};
      data_out_r   <= {DATA_W{1'b0}};
      frame_done_r <= 1'b0;
      frame_ok_r   <= 1'b0;
    end else begin
      frame_done_r <= fire_s;
      if (start_s) begin
        par_r     <= PAR_INIT;
        bit_cnt_r <= {CNT_W{1'b0}};
      end else if (shift_s) begin
        shreg_r[bit_cnt_r] <= x;
        par_r              <= par_fold(par_r, x);
        // Hold on the last data beat so the counter never exceeds DATA_W-1.
        if (bit_cnt_r != LAST_BIT) begin
          bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        end
      end
      if (fire_s) begin
        data_out_r <= shreg_r;
        frame_ok_r <= (x == par_r);
      end
    end
  end

  assign st         = state_r;
  assign data_out   = data_out_r;
  assign frame_done = frame_done_r;
  assign frame_ok   = frame_ok_r;

`ifdef PARITY_ERR_CNT_EN
  logic err_inc_s;
  assign err_inc_s = fire_s & (x != par_r);

  parity_err_counter #(
    .ERR_CNT_W(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (err_inc_s),
    .count(err_count)
  );
`else
  assign err_count = {ERR_CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: three instances (even/8-bit count,
// even/2-bit count, odd) share one serial stream and are checked against a frame-level model.
module tb_serial_parity_checker;

`ifdef PARITY_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  localparam logic [2:0] ODDV = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x_valid = 1'b0;
  logic x = 1'b1;

  logic [2:0]      par;
  logic [2:0]      fd;
  logic [2:0]      fok;
  logic [2:0][1:0] st;
  logic [2:0][7:0] dout;
  logic [7:0]      err_a;
  logic [1:0]      err_b;
  logic [7:0]      err_c;

  always #5 clk = ~clk;

  serial_parity_checker #(.DATA_W(8), .ODD(0), .ERR_CNT_W(8)) dut_even (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .parity(par[0]), .st(st[0]),
    .data_out(dout[0]), .frame_done(fd[0]), .frame_ok(fok[0]), .err_count(err_a));

  serial_parity_checker #(.DATA_W(8), .ODD(0), .ERR_CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .parity(par[1]), .st(st[1]),
    .data_out(dout[1]), .frame_done(fd[1]), .frame_ok(fok[1]), .err_count(err_b));

  serial_parity_checker #(.DATA_W(8), .ODD(1), .ERR_CNT_W(8)) dut_odd (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x(x), .parity(par[2]), .st(st[2]),
    .data_out(dout[2]), .frame_done(fd[2]), .frame_ok(fok[2]), .err_count(err_c));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [2:0] run;
  logic [2:0] exp_ok;
  logic [7:0] exp_err [3];
  logic [7:0] last_data;

  int cyc = 0;
  int pulse_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (fd[0] === 1'b1) pulse_cyc.push_back(cyc);

  function automatic logic [7:0] err_of(input int k);
    if (k == 0) return err_a;
    else if (k == 1) return {6'b0, err_b};
    else return err_c;
  endfunction

  function automatic logic [7:0] err_max(input int k);
    return (k == 1) ? 8'd3 : 8'd255;
  endfunction

  task automatic beat(input logic v, input logic b, input logic in_data);
    logic e;
    @(negedge clk);
    x_valid = v;
    x = b;
    #1;
    for (int k = 0; k < 3; k++) begin
      e = run[k] ^ (in_data & v & b);
      n_tests++;
      if (par[k] !== e) begin
        n_fail++;
        $display("FAIL parity dut%0d: got %b want %b", k, par[k], e);
      end
      if (in_data && v) run[k] = run[k] ^ b;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    x_valid = 1'b0;
    x = 1'b1;
    @(posedge clk);
    #1;
    run = ODDV;
    exp_ok = 3'b000;
    last_data = 8'h00;
    for (int k = 0; k < 3; k++) begin
      exp_err[k] = 8'h00;
      n_tests++;
      if (st[k] !== 2'd0 || dout[k] !== 8'h00 || fd[k] !== 1'b0 || fok[k] !== 1'b0 ||
          err_of(k) !== 8'h00 || par[k] !== run[k]) begin
        n_fail++;
        $display("FAIL reset dut%0d: st=%0d dout=%h fd=%b ok=%b err=%0d par=%b want st=0 dout=00 fd=0 ok=0 err=0 par=%b",
                 k, st[k], dout[k], fd[k], fok[k], err_of(k), par[k], run[k]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic pbit,
                            input int stall_at, input int stall_len);
    logic ok;
    beat(1'b1, 1'b0, 1'b0);
    run = ODDV;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          beat(1'b0, 1'($urandom), 1'b1);
          for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (st[k] !== 2'd1) begin
              n_fail++;
              $display("FAIL stall_state dut%0d: got %0d want 1", k, st[k]);
            end
          end
        end
      end
      beat(1'b1, data[i], 1'b1);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (st[k] !== 2'd2) begin
        n_fail++;
        $display("FAIL par_state dut%0d: got %0d want 2", k, st[k]);
      end
    end
    beat(1'b1, pbit, 1'b0);
    for (int k = 0; k < 3; k++) begin
      ok = (((^data) ^ pbit) == ODDV[k]);
      exp_ok[k] = ok;
      if (!ok && CNT_EN && exp_err[k] < err_max(k)) exp_err[k] = exp_err[k] + 8'd1;
      n_tests++;
      if (fd[k] !== 1'b1 || dout[k] !== data || fok[k] !== ok || err_of(k) !== exp_err[k]) begin
        n_fail++;
        $display("FAIL frame dut%0d: fd=%b dout=%h ok=%b err=%0d want fd=1 dout=%h ok=%b err=%0d",
                 k, fd[k], dout[k], fok[k], err_of(k), data, ok, exp_err[k]);
      end
    end
    last_data = data;
  endtask

  task automatic idle_beat();
    logic v;
    logic b;
    v = 1'($urandom);
    b = v ? 1'b1 : 1'($urandom);
    beat(v, b, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (fd[k] !== 1'b0 || dout[k] !== last_data || fok[k] !== exp_ok[k] || err_of(k) !== exp_err[k]) begin
        n_fail++;
        $display("FAIL idle_hold dut%0d: fd=%b dout=%h ok=%b err=%0d want fd=0 dout=%h ok=%b err=%0d",
                 k, fd[k], dout[k], fok[k], err_of(k), last_data, exp_ok[k], exp_err[k]);
      end
    end
  endtask

  task automatic test_reset();
    reset_dut();
  endtask

  task automatic test_basic_frames();
    send_frame(8'hA5, 1'b0, 9, 0);
    idle_beat();
    send_frame(8'hA5, 1'b1, 9, 0);
    idle_beat();
  endtask

  task automatic test_err_saturation();
    for (int i = 0; i < 4; i++) begin
      send_frame(8'hA5, 1'b1, 9, 0);
      idle_beat();
    end
  endtask

  task automatic test_odd_zero();
    send_frame(8'h00, 1'b1, 9, 0);
    idle_beat();
  endtask

  task automatic test_stall();
    send_frame(8'h3C, 1'b0, 4, 3);
    idle_beat();
  endtask

  task automatic test_abort();
    int n0;
    n0 = pulse_cyc.size();
    beat(1'b1, 1'b0, 1'b0);
    run = ODDV;
    for (int i = 0; i < 4; i++) beat(1'b1, 1'($urandom), 1'b1);
    reset_dut();
    send_frame(8'h81, 1'b0, 9, 0);
    idle_beat();
    n_tests++;
    if (pulse_cyc.size() != n0 + 1) begin
      n_fail++;
      $display("FAIL abort_pulses: got %0d want %0d", pulse_cyc.size() - n0, 1);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = pulse_cyc.size();
    send_frame(8'hFF, 1'b0, 9, 0);
    send_frame(8'h01, 1'b1, 9, 0);
    idle_beat();
    n_tests++;
    if (pulse_cyc.size() != n0 + 2) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d want 2", pulse_cyc.size() - n0);
    end else begin
      n_tests++;
      if (pulse_cyc[n0 + 1] - pulse_cyc[n0] != 10) begin
        n_fail++;
        $display("FAIL b2b_spacing: got %0d want 10", pulse_cyc[n0 + 1] - pulse_cyc[n0]);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      send_frame(8'($urandom), 1'($urandom), int'($urandom_range(0, 11)), int'($urandom_range(1, 3)));
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) idle_beat();
    end
  endtask

  initial begin
    run = ODDV;
    exp_ok = 3'b000;
    last_data = 8'h00;
    for (int k = 0; k < 3; k++) exp_err[k] = 8'h00;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic_frames();
    test_err_saturation();
    test_odd_zero();
    test_stall();
    test_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_parity_checker.md
# serial_parity_checker

Parametrised serial-frame parity checker that succeeds the single-bit Mealy parity FSM. It accepts one serial bit per qualified clock, frames `DATA_W` data bits between a start bit and a parity bit, and computes even or odd parity. It emits a running Mealy parity output, the deserialised word, and a per-frame pass/fail pulse. It sits behind the serial receive pin logic and feeds the word-level consumer.

## Interface
Parameters:
- `DATA_W`, default 8: data bits per frame; legal range 2..32.
- `ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `ERR_CNT_W`, default 8: width of the error counter.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `x_valid` in 1: qualifies `x` for this cycle; when low the block holds all state.
- `x` in 1: serial bit, LSB first.
- `parity` out 1: Mealy output, combinational; parity including the current `x` (see Operation).
- `st` out 2: current FSM state encoding.
- `data_out` out `DATA_W`: last completed frame's data word.
- `frame_done` out 1: one-cycle pulse when a frame completes.
- `frame_ok` out 1: valid with `frame_done`; high if the received parity bit matched.
- `err_count` out `ERR_CNT_W`: saturating count of parity failures.

## Operation
- States: IDLE=0, DATA=1, PAR=2; encoding 3 is illegal and returns to IDLE on the next clock.
- IDLE:
  - `x_valid & ~x` (start bit) → DATA; clear the running parity to `ODD` and `bit_cnt` to 0.
  - `x_valid & x` → stay in IDLE (line idle).
- DATA:
  - Each `x_valid` shifts `x` into `shreg[bit_cnt]`, XORs `x` into the running parity, and increments `bit_cnt`.
  - On the beat where `bit_cnt == DATA_W-1` → PAR.
- PAR:
  - On `x_valid`, `frame_ok` is the result of `x == running_parity`.
  - Load `data_out <= shreg`, pulse `frame_done`, then → IDLE.
- `x_valid` low in any state: no transition, no counter change, no shift.
- `parity` is driven combinationally:
  - In DATA: `running_parity ^ (x & x_valid)`.
  - In PAR and IDLE: `running_parity`.
  - It is stable only after `x` settles.
- `data_out` holds its value between frames. Failed frames still update `data_out`.
- `frame_ok` holds its last value between pulses.
- `bit_cnt` width is `$clog2(DATA_W)`. It never wraps beyond `DATA_W-1`.
- `rst_n` low at any clock overrides all other activity, including mid-frame. A partial frame is discarded and produces no `frame_done`.

## Timing
- Reset values (one clock after `rst_n` sampled low): `st`=IDLE, `data_out`=0, `frame_done`=0, `frame_ok`=0, `err_count`=0, running parity=`ODD`, `parity`=`ODD`.
- Frame latency: `frame_done` rises in the clock after the parity bit is sampled and lasts exactly one cycle. Minimum frame spacing is `DATA_W+2` valid beats.
- A start bit may arrive in the cycle `frame_done` is high. Back-to-back frames incur no bubble.
- `err_count` increments in the same cycle `frame_done` is asserted with `frame_ok`=0, and saturates at all-ones.

## Configuration
- `PARITY_ERR_CNT_EN` defined: the error counter is instantiated and `err_count` behaves as specified above.
- `PARITY_ERR_CNT_EN` undefined: no counter logic is built, and `err_count` is tied to 0. All other behaviour is identical.

## Structure
- Shared package `parity_pkg` holds:
  - the `parity_state_t` typedef (2-bit enum, IDLE/DATA/PAR);
  - the state encoding constants;
  - the `PAR_EVEN`/`PAR_ODD` constants.
- One sub-module, `parity_err_counter`: a saturating up-counter with `clk`, `rst_n`, `inc`, and `count[ERR_CNT_W]`. It is instantiated only under `PARITY_ERR_CNT_EN`.

## Test plan
Defaults (`DATA_W`=8, `ODD`=0) unless noted.
- Reset then frame 0, 0xA5 LSB first, parity 0 → `frame_done` pulse, `data_out`=0xA5, `frame_ok`=1, `err_count`=0.
- Same frame with parity bit 1 → `frame_ok`=0, `err_count`=1; with `ERR_CNT_W`=2, four more bad frames leave `err_count`=3.
- `ODD`=1, frame 0x00 with parity 1 → `frame_ok`=1. During the data bits `parity` stays 1 until the first 1-bit arrives.
- Frame 0x3C with `x_valid` low for 3 cycles mid-data → `st` held at DATA, result identical to an unstalled frame (`data_out`=0x3C).
- `rst_n` low after 4 data bits, then a full frame 0x81 → no `frame_done` for the aborted frame, `data_out`=0x81, `frame_ok`=1.
- Two back-to-back frames 0xFF then 0x01, start bit in the `frame_done` cycle → two pulses exactly 10 cycles apart, `data_out` 0xFF then 0x01.
